// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, whole-scan debounce.
// Optional build macro KEYPAD_GHOST_REJECT_EN discards snapshots with 3+ pressed keys.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  rows_n,
  output logic [3:0]  cols_n,
  output logic [15:0] buttons,
  output logic        changed
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_MAX  = CW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    DRIVE,
    SAMPLE,
    COMPARE
  } state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [1:0]    col;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [15:0]   snapshot;
  logic [15:0]   prev_snapshot;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] ns;
  logic          match;
  logic          ghost;

`ifdef KEYPAD_GHOST_REJECT_EN
  function automatic logic [4:0] count_zeros(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, ~v[i]};
    return n;
  endfunction

  // Three or more closed switches can alias a phantom key through the matrix.
  assign ghost = (count_zeros(snapshot) >= 5'd3);
`else
  assign ghost = 1'b0;
`endif

  // Next stable count, saturating so a long hold never wraps back to zero.
  always_comb begin
    ns    = '0;
    match = (snapshot == prev_snapshot) && !ghost;
    if (match)
      ns = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + 1'b1;
  end

  // NOTE: every register here uses <= so all reads see pre-edge values, which
  // keeps the synchroniser two stages deep and the FSM free of ordering races.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= DRIVE;
      settle_cnt    <= '0;
      col           <= 2'd0;
      cols_n        <= 4'b1110;
      row_meta      <= 4'hF;
      row_sync      <= 4'hF;
      snapshot      <= 16'hFFFF;
      prev_snapshot <= 16'hFFFF;
      stable_cnt    <= '0;
      buttons       <= 16'hFFFF;
      changed       <= 1'b0;
    end else begin
      row_meta <= rows_n;
      row_sync <= row_meta;
      changed  <= 1'b0;

      case (state)
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        SAMPLE: begin
          for (int r = 0; r < 4; r++)
            snapshot[4*r + int'(col)] <= row_sync[r];
          if (col != 2'd3) begin
            col    <= col + 2'd1;
            cols_n <= {cols_n[2:0], cols_n[3]};
            state  <= DRIVE;
          end else begin
            state <= COMPARE;
          end
        end

        COMPARE: begin
          stable_cnt    <= ns;
          prev_snapshot <= snapshot;
          if (!ghost && ns == STABLE_MAX && snapshot != buttons) begin
            buttons <= snapshot;
            changed <= 1'b1;
          end
          col    <= 2'd0;
          cols_n <= 4'b1110;
          state  <= DRIVE;
        end

        default: state <= DRIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SETTLE_CYCLES=4, DEBOUNCE_SCANS=3 (21-cycle scan).
// A behavioural keypad pulls rows low for pressed keys whose column is driven.
module tb_keypad_scanner;

  localparam int SCAN = 21;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic [15:0] buttons;
  logic        changed;

  logic [15:0] pressed = 16'h0000;
  int          assertions = 0;
  int          failures = 0;
  int          pulse_cnt = 0;

  keypad_scanner #(
    .SETTLE_CYCLES (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rows_n (rows_n),
    .cols_n (cols_n),
    .buttons(buttons),
    .changed(changed)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r + c] && !cols_n[c]) rows_n[r] = 1'b0;
  end

  always @(posedge clk) if (changed === 1'b1) pulse_cnt++;

  // Leaves the bench at a negedge where the DUT is in its post-reset state (scan cycle 0).
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pulse_cnt = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_cols;
    pressed = 16'h0000;
    do_reset();
    assertions++;
    if (buttons !== 16'hFFFF) begin
      failures++;
      $display("FAIL reset_buttons: got %h expected FFFF", buttons);
    end
    assertions++;
    if (changed !== 1'b0) begin
      failures++;
      $display("FAIL reset_changed: got %b expected 0", changed);
    end
    for (int k = 0; k < 2 * SCAN; k++) begin
      int ph;
      ph = k % SCAN;
      case ((ph < 20) ? ph / 5 : 3)
        0:       exp_cols = 4'b1110;
        1:       exp_cols = 4'b1101;
        2:       exp_cols = 4'b1011;
        default: exp_cols = 4'b0111;
      endcase
      assertions++;
      if (cols_n !== exp_cols) begin
        failures++;
        $display("FAIL cols_seq[%0d]: got %b expected %b", k, cols_n, exp_cols);
      end
      wait_cycles(1);
    end
    assertions++;
    if (buttons !== 16'hFFFF || pulse_cnt != 0) begin
      failures++;
      $display("FAIL idle_hold: buttons %h pulses %0d expected FFFF and 0", buttons, pulse_cnt);
    end
  endtask

  task automatic test_press_hold();
    pressed = 16'h0040;
    do_reset();
    wait_cycles(62);
    assertions++;
    if (buttons !== 16'hFFFF || changed !== 1'b0) begin
      failures++;
      $display("FAIL press_before: buttons %h changed %b expected FFFF 0", buttons, changed);
    end
    wait_cycles(1);
    assertions++;
    if (buttons !== 16'hFFBF || changed !== 1'b1) begin
      failures++;
      $display("FAIL press_update: buttons %h changed %b expected FFBF 1", buttons, changed);
    end
    wait_cycles(1);
    assertions++;
    if (changed !== 1'b0) begin
      failures++;
      $display("FAIL press_pulse_width: changed %b expected 0", changed);
    end
    wait_cycles(5 * SCAN - 1);
    assertions++;
    if (buttons !== 16'hFFBF || pulse_cnt != 1) begin
      failures++;
      $display("FAIL press_held: buttons %h pulses %0d expected FFBF 1", buttons, pulse_cnt);
    end
  endtask

  // Entered at a scan boundary with FFBF reported.
  task automatic test_release();
    pressed = 16'h0000;
    pulse_cnt = 0;
    wait_cycles(62);
    assertions++;
    if (buttons !== 16'hFFBF) begin
      failures++;
      $display("FAIL release_before: buttons %h expected FFBF", buttons);
    end
    wait_cycles(1);
    assertions++;
    if (buttons !== 16'hFFFF || changed !== 1'b1) begin
      failures++;
      $display("FAIL release_update: buttons %h changed %b expected FFFF 1", buttons, changed);
    end
    wait_cycles(3 * SCAN);
    assertions++;
    if (buttons !== 16'hFFFF || pulse_cnt != 1) begin
      failures++;
      $display("FAIL release_pulses: buttons %h pulses %0d expected FFFF 1", buttons, pulse_cnt);
    end
  endtask

  task automatic test_flicker();
    pressed = 16'h0040;
    do_reset();
    for (int s = 1; s <= 10; s++) begin
      pressed = (s % 2 == 1) ? 16'h0040 : 16'h0000;
      wait_cycles(SCAN);
    end
    pressed = 16'h0000;
    wait_cycles(2);
    assertions++;
    if (buttons !== 16'hFFFF || pulse_cnt != 0) begin
      failures++;
      $display("FAIL flicker: buttons %h pulses %0d expected FFFF 0", buttons, pulse_cnt);
    end
  endtask

  task automatic test_reset_mid_scan();
    pressed = 16'h0040;
    do_reset();
    wait_cycles(4 * SCAN + 11);
    assertions++;
    if (buttons !== 16'hFFBF || cols_n !== 4'b1011) begin
      failures++;
      $display("FAIL midreset_pre: buttons %h cols %b expected FFBF 1011", buttons, cols_n);
    end
    reset_n = 1'b0;
    wait_cycles(1);
    assertions++;
    if (cols_n !== 4'b1110 || buttons !== 16'hFFFF || changed !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: cols %b buttons %h changed %b expected 1110 FFFF 0",
               cols_n, buttons, changed);
    end
    reset_n = 1'b1;
    pulse_cnt = 0;
    wait_cycles(62);
    assertions++;
    if (buttons !== 16'hFFFF) begin
      failures++;
      $display("FAIL midreset_early: buttons %h expected FFFF", buttons);
    end
    wait_cycles(1);
    assertions++;
    if (buttons !== 16'hFFBF || changed !== 1'b1) begin
      failures++;
      $display("FAIL midreset_update: buttons %h changed %b expected FFBF 1", buttons, changed);
    end
  endtask

  task automatic test_multi_key();
    logic [15:0] exp_b;
`ifdef KEYPAD_GHOST_REJECT_EN
    exp_b = 16'hFFFF;
`else
    exp_b = 16'hFFEC;
`endif
    pressed = 16'h0013;
    do_reset();
    wait_cycles(63);
    assertions++;
    if (buttons !== exp_b) begin
      failures++;
      $display("FAIL multi_key: buttons %h expected %h", buttons, exp_b);
    end
    wait_cycles(2 * SCAN);
    assertions++;
    if (buttons !== exp_b || pulse_cnt != ((exp_b == 16'hFFFF) ? 0 : 1)) begin
      failures++;
      $display("FAIL multi_key_hold: buttons %h pulses %0d expected %h", buttons, pulse_cnt, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_press_hold();
    test_release();
    test_flicker();
    test_reset_mid_scan();
    test_multi_key();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
